// File: rtl/nec_ir_pkg.sv
// Shared NEC transmitter definitions: unit counts per protocol element,
// the sequencer state encoding and the frame packing helper.
package nec_ir_pkg;

  localparam logic [7:0] LEAD_MARK_U  = 8'd16;
  localparam logic [7:0] LEAD_SPACE_U = 8'd8;
  localparam logic [7:0] REP_SPACE_U  = 8'd4;
  localparam logic [7:0] BIT_MARK_U   = 8'd1;
  localparam logic [7:0] ZERO_SPACE_U = 8'd1;
  localparam logic [7:0] ONE_SPACE_U  = 8'd3;
  localparam logic [7:0] STOP_U       = 8'd1;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LEAD_MARK  = 3'd1,
    ST_LEAD_SPACE = 3'd2,
    ST_REP_SPACE  = 3'd3,
    ST_BIT_MARK   = 3'd4,
    ST_BIT_SPACE  = 3'd5,
    ST_STOP_MARK  = 3'd6,
    ST_GAP        = 3'd7
  } nec_state_e;

  // NEC frame word; bit 0 goes on the air first.
  function automatic logic [31:0] nec_frame(input logic [7:0] addr, input logic [7:0] cmd);
    return {~cmd, cmd, ~addr, addr};
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Carrier divider: toggles its phase every CARRIER_HALF enabled cycles and
// is forced to phase 0 (low) whenever clr is high.
module ir_carrier_gen #(
  parameter int CARRIER_HALF = 658
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic carrier
);

  localparam int CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

  logic [CW-1:0] half_cnt_r;
  logic          phase_r;

  // Half-period counter and phase toggle, cleared synchronously by clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_cnt_r <= '0;
      phase_r    <= 1'b0;
    end else if (clr) begin
      half_cnt_r <= '0;
      phase_r    <= 1'b0;
    end else if (en) begin
      if (half_cnt_r == CW'(CARRIER_HALF - 1)) begin
        half_cnt_r <= '0;
        phase_r    <= ~phase_r;
      end else begin
        half_cnt_r <= half_cnt_r + CW'(1);
      end
    end else begin
      half_cnt_r <= half_cnt_r;
      phase_r    <= phase_r;
    end
  end

  assign carrier = phase_r;

endmodule

// File: rtl/nec_ir_transmitter.sv
// NEC infrared transmitter: sequences leader, 32 LSB-first data bits, stop
// mark and trailing gap (or a repeat code), producing the mark/space
// envelope and the carrier-modulated LED drive, both registered.
module nec_ir_transmitter
  import nec_ir_pkg::*;
#(
  parameter int UNIT_CYCLES  = 28125,
  parameter int CARRIER_HALF = 658,
  parameter int GAP_UNITS    = 72
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       repeat_req,
  input  logic [7:0] address,
  input  logic [7:0] command,
  output logic       busy,
  output logic       done,
  output logic       ir_env,
  output logic       ir_tx
);

  localparam int UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

  nec_state_e    state_r;
  logic [31:0]   frame_r;
  logic [4:0]    bit_idx_r;
  logic [7:0]    units_r;
  logic          rep_mode_r;
  logic [UW-1:0] unit_cnt_r;
  logic          busy_r;
  logic          done_r;
  logic          env_r;

  logic [7:0]    dur_s;
  logic          unit_tick_s;
  logic          state_exit_s;
  logic          carrier_s;
  logic          carrier_clr_s;

  assign unit_tick_s  = (state_r != ST_IDLE) && (unit_cnt_r == UW'(UNIT_CYCLES - 1));
  assign state_exit_s = unit_tick_s && (units_r == (dur_s - 8'd1));

  // Length of the current state in NEC units.
  always_comb begin
    dur_s = 8'd1;
    case (state_r)
      ST_LEAD_MARK:  dur_s = LEAD_MARK_U;
      ST_LEAD_SPACE: dur_s = LEAD_SPACE_U;
      ST_REP_SPACE:  dur_s = REP_SPACE_U;
      ST_BIT_MARK:   dur_s = BIT_MARK_U;
      ST_BIT_SPACE:  dur_s = frame_r[0] ? ONE_SPACE_U : ZERO_SPACE_U;
      ST_STOP_MARK:  dur_s = STOP_U;
      ST_GAP:        dur_s = 8'(GAP_UNITS);
      default:       dur_s = 8'd1;
    endcase
  end

  // Unit timer: free-runs 0..UNIT_CYCLES-1 while a sequence is active.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      unit_cnt_r <= '0;
    end else if (state_r == ST_IDLE || unit_tick_s) begin
      unit_cnt_r <= '0;
    end else begin
      unit_cnt_r <= unit_cnt_r + UW'(1);
    end
  end

  // Sequencer: acceptance, per-state unit counting and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      frame_r    <= 32'd0;
      bit_idx_r  <= 5'd0;
      units_r    <= 8'd0;
      rep_mode_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      env_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (state_r == ST_IDLE) begin
        if (start || repeat_req) begin
          frame_r    <= start ? nec_frame(address, command) : 32'd0;
          rep_mode_r <= ~start;
          bit_idx_r  <= 5'd0;
          units_r    <= 8'd0;
          busy_r     <= 1'b1;
          env_r      <= 1'b1;
          state_r    <= ST_LEAD_MARK;
        end
      end else if (unit_tick_s && !state_exit_s) begin
        units_r <= units_r + 8'd1;
      end else if (state_exit_s) begin
        units_r <= 8'd0;
        case (state_r)
          ST_LEAD_MARK: begin
            state_r <= rep_mode_r ? ST_REP_SPACE : ST_LEAD_SPACE;
            env_r   <= 1'b0;
          end
          ST_LEAD_SPACE: begin
            state_r <= ST_BIT_MARK;
            env_r   <= 1'b1;
          end
          ST_REP_SPACE: begin
            state_r <= ST_STOP_MARK;
            env_r   <= 1'b1;
          end
          ST_BIT_MARK: begin
            state_r <= ST_BIT_SPACE;
            env_r   <= 1'b0;
          end
          ST_BIT_SPACE: begin
            frame_r <= {1'b0, frame_r[31:1]};
            env_r   <= 1'b1;
            if (bit_idx_r == 5'd31) begin
              state_r <= ST_STOP_MARK;
            end else begin
              bit_idx_r <= bit_idx_r + 5'd1;
              state_r   <= ST_BIT_MARK;
            end
          end
          ST_STOP_MARK: begin
            state_r <= ST_GAP;
            env_r   <= 1'b0;
          end
          ST_GAP: begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
          default: begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            env_r   <= 1'b0;
          end
        endcase
      end
    end
  end

  // Carrier phase is held at 0 through every space and on the edge a mark
  // ends, so each mark starts with a full low half-period.
  assign carrier_clr_s = ~env_r | state_exit_s;

  ir_carrier_gen #(
    .CARRIER_HALF(CARRIER_HALF)
  ) u_carrier (
    .clk    (clk),
    .rst_n  (reset_n),
    .en     (env_r),
    .clr    (carrier_clr_s),
    .carrier(carrier_s)
  );

  assign busy   = busy_r;
  assign done   = done_r;
  assign ir_env = env_r;
  assign ir_tx  = carrier_s;

endmodule

// File: tb/tb_nec_ir_transmitter.sv
// Self-checking bench for nec_ir_transmitter with a per-cycle waveform model
// built from the NEC segment list (unit counts per mark/space).
module tb_nec_ir_transmitter;

  localparam int UC = 10;
  localparam int CH = 2;
  localparam int GU = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       repeat_req = 1'b0;
  logic [7:0] address = 8'd0;
  logic [7:0] command = 8'd0;
  logic       busy, done, ir_env, ir_tx;

  int n_cmp = 0;
  int n_bad = 0;
  int done_seen = 0;
  int done_exp = 0;
  int bc;
  bit exp_env_q[$];

  always #5 clk = ~clk;

  nec_ir_transmitter #(
    .UNIT_CYCLES(UC),
    .CARRIER_HALF(CH),
    .GAP_UNITS(GU)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .repeat_req(repeat_req),
    .address(address),
    .command(command),
    .busy(busy),
    .done(done),
    .ir_env(ir_env),
    .ir_tx(ir_tx)
  );

  // Count every done pulse seen over the whole run.
  always @(negedge clk) begin
    if (done === 1'b1) done_seen++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_seg(input bit lvl, input int units);
    for (int j = 0; j < units * UC; j++) exp_env_q.push_back(lvl);
  endtask

  // Expected envelope, one entry per busy cycle.
  task automatic build_model(input bit rep, input logic [31:0] frame);
    exp_env_q.delete();
    push_seg(1'b1, 16);
    if (rep) begin
      push_seg(1'b0, 4);
    end else begin
      push_seg(1'b0, 8);
      for (int b = 0; b < 32; b++) begin
        push_seg(1'b1, 1);
        push_seg(1'b0, frame[b] ? 3 : 1);
      end
    end
    push_seg(1'b1, 1);
    push_seg(1'b0, GU);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_env"}, 32'(ir_env), 32'd0);
    check_eq({tag, "_tx"}, 32'(ir_tx), 32'd0);
  endtask

  // Issue one request at a negedge and check every cycle until idle again.
  task automatic run_txn(input bit s, input bit r, input logic [7:0] a, input logic [7:0] c,
                         input int abort_at, input bit noise, output int busy_cycles);
    bit          rep;
    logic [31:0] fr;
    int          len;
    int          k;
    bit          e;
    bit          et;
    rep = !s && r;
    fr  = {~c, c, ~a, a};
    build_model(rep, fr);
    len = exp_env_q.size();
    k = 0;
    busy_cycles = 0;
    address = a;
    command = c;
    start = s;
    repeat_req = r;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      e  = exp_env_q[i];
      et = e && (((k / CH) % 2) == 1);
      k  = e ? k + 1 : 0;
      check_eq("env", 32'(ir_env), 32'(e));
      check_eq("tx", 32'(ir_tx), 32'(et));
      check_eq("busy", 32'(busy), 32'd1);
      check_eq("done_early", 32'(done), 32'd0);
      if (busy === 1'b1) busy_cycles++;
      if (i == abort_at) begin
        start = 1'b0;
        repeat_req = 1'b0;
        #1 reset_n = 1'b0;
        #1 check_idle("abort");
        @(negedge clk);
        check_idle("in_reset");
        @(negedge clk);
        reset_n = 1'b1;
        return;
      end
      if (noise && i < len - 1) begin
        start = ($urandom_range(0, 39) == 0);
        repeat_req = ($urandom_range(0, 39) == 0);
        address = 8'($urandom);
        command = 8'($urandom);
      end else begin
        start = 1'b0;
        repeat_req = 1'b0;
      end
    end
    @(negedge clk);
    check_eq("done_pulse", 32'(done), 32'd1);
    check_eq("busy_end", 32'(busy), 32'd0);
    check_eq("env_end", 32'(ir_env), 32'd0);
    check_eq("tx_end", 32'(ir_tx), 32'd0);
    done_exp++;
    @(negedge clk);
    check_idle("post");
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_idle("reset");
    reset_n = 1'b1;
    repeat (100) begin
      @(negedge clk);
      check_idle("idle");
    end

    run_txn(1'b1, 1'b0, 8'h00, 8'h18, -1, 1'b0, bc);
    check_eq("frame_busy_len", 32'(bc), 32'd1250);

    run_txn(1'b0, 1'b1, 8'($urandom), 8'($urandom), -1, 1'b0, bc);
    check_eq("rep_busy_len", 32'(bc), 32'd250);

    run_txn(1'b1, 1'b1, 8'hA5, 8'h3C, -1, 1'b1, bc);
    check_eq("both_busy_len", 32'(bc), 32'd1250);

    for (int t = 0; t < 8; t++) begin
      int kind;
      kind = $urandom_range(0, 2);
      run_txn(kind != 1, kind != 0, 8'($urandom), 8'($urandom), -1, 1'b1, bc);
      check_eq("rand_busy_len", 32'(bc), 32'(exp_env_q.size()));
    end

    run_txn(1'b1, 1'b0, 8'h00, 8'h18, 300, 1'b0, bc);
    repeat (20) begin
      @(negedge clk);
      check_idle("after_abort");
    end
    run_txn(1'b1, 1'b0, 8'($urandom), 8'($urandom), -1, 1'b0, bc);
    check_eq("restart_busy_len", 32'(bc), 32'(exp_env_q.size()));

    check_eq("done_count", 32'(done_seen), 32'(done_exp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
